// File: rtl/pc_pkg.sv
// Shared charset definitions for the password candidate generator and the cracker.
package pc_pkg;

  localparam int         CHARSET_SIZE = 36;
  localparam logic [5:0] CHARSET_MAX  = 6'd35;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIN
  } state_t;

  // Indices 0-9 map to '0'-'9', 10-35 map to 'a'-'z'.
  function automatic logic [7:0] idx_to_ascii(input logic [5:0] idx);
    if (idx < 6'd10) return 8'h30 + {2'b00, idx};
    else             return 8'h61 + {2'b00, idx} - 8'd10;
  endfunction

endpackage

// File: rtl/password_candidate_gen_charset_digit.sv
// One odometer digit: loads `from`, counts up to `to`, then wraps and carries.
module charset_digit
  import pc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] from,
  input  logic [5:0] to,
  input  logic       load,
  input  logic       inc,
  output logic [5:0] value,
  output logic [5:0] next_value,
  output logic       carry_out
);

  assign carry_out = inc && (value == to);

  // next_value is exported so the parent can register the ASCII form in step.
  always_comb begin
    // NOTE: default assignment first so every path drives next_value (no latch).
    next_value = value;
    if (load)           next_value = from;
    else if (carry_out) next_value = from;
    else if (inc)       next_value = value + 6'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (rst) value <= '0;
    else     value <= next_value;
  end

endmodule

// File: rtl/password_candidate_gen.sv
// Enumerates all NCHARS-long passwords over a charset index range, one per handshake.
module password_candidate_gen
  import pc_pkg::*;
#(
  parameter int         NCHARS      = 4,
  parameter logic [5:0] CHARSET_MAX = pc_pkg::CHARSET_MAX
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [5:0]            from,
  input  logic [5:0]            to,
  input  logic                  stop,
  output logic                  cand_valid,
  input  logic                  cand_ready,
  output logic [8*NCHARS-1:0]   candidate,
  output logic [20:0]           cand_index,
  output logic                  busy,
  output logic                  done
);

  state_t            state;
  logic [5:0]        from_q, to_q;
  logic [5:0]        to_clamped, digit_from;
  logic              empty, load, hs, finish;
  logic [5:0]        value      [NCHARS];
  logic [5:0]        next_value [NCHARS];
  logic [NCHARS-1:0] inc, carry;
  logic [8*NCHARS-1:0] next_cand;

  assign to_clamped = (to > CHARSET_MAX) ? CHARSET_MAX : to;
  assign empty      = from > to_clamped;
  assign load       = (state == ST_IDLE) && start && !empty;
  assign hs         = (state == ST_RUN) && cand_ready && !stop;
  // Carry out of the leftmost digit means every digit sat at `to`: last candidate.
  assign finish     = carry[0];
  // Digits load the live `from` in IDLE and wrap to the captured one while running.
  assign digit_from = (state == ST_IDLE) ? from : from_q;

  for (genvar i = 0; i < NCHARS; i++) begin : g_digit
    if (i == NCHARS - 1) begin : g_lsd
      assign inc[i] = hs;
    end else begin : g_inner
      assign inc[i] = carry[i+1];
    end

    charset_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .from       (digit_from),
      .to         (to_q),
      .load       (load),
      .inc        (inc[i]),
      .value      (value[i]),
      .next_value (next_value[i]),
      .carry_out  (carry[i])
    );

    assign next_cand[8*(NCHARS-1-i) +: 8] = idx_to_ascii(next_value[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      from_q     <= '0;
      to_q       <= '0;
      cand_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      candidate  <= '0;
      cand_index <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            from_q <= from;
            to_q   <= to_clamped;
            if (empty) begin
              state <= ST_FIN;
              done  <= 1'b1;
            end else begin
              state      <= ST_RUN;
              cand_valid <= 1'b1;
              busy       <= 1'b1;
              cand_index <= '0;
              candidate  <= next_cand;
            end
          end
        end
        ST_RUN: begin
          if (stop) begin
            state      <= ST_IDLE;
            cand_valid <= 1'b0;
            busy       <= 1'b0;
          end else if (hs) begin
            if (finish) begin
              state      <= ST_FIN;
              cand_valid <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else begin
              cand_index <= cand_index + 21'd1;
              candidate  <= next_cand;
            end
          end
        end
        ST_FIN: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_password_candidate_gen.sv
// Directed bench for password_candidate_gen with an arithmetic enumeration model.
module tb_password_candidate_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  from = '0;
  logic [5:0]  to = '0;
  logic        stop = 1'b0;
  logic        cand_ready = 1'b0;
  logic        cand_valid;
  logic [31:0] candidate;
  logic [20:0] cand_index;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  // Model state: expected valid/done, current ordinal and captured range.
  bit  chk_en = 1'b0;
  bit  m_valid = 1'b0;
  bit  m_done = 1'b0;
  int  m_idx = 0;
  int  m_lo = 0;
  int  m_hi = 0;

  int          n_hs = 0;
  int          n_done = 0;
  int          n_valid = 0;
  logic [31:0] seen [128];

  password_candidate_gen dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .from       (from),
    .to         (to),
    .stop       (stop),
    .cand_valid (cand_valid),
    .cand_ready (cand_ready),
    .candidate  (candidate),
    .cand_index (cand_index),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] asc(input int d);
    return (d < 10) ? 8'(48 + d) : 8'(97 + d - 10);
  endfunction

  // Candidate k is k written in base (hi-lo+1), each digit offset by lo.
  function automatic logic [31:0] model_cand(input int k, input int lo, input int hi);
    int n = hi - lo + 1;
    int r = k;
    logic [31:0] s = '0;
    for (int p = 3; p >= 0; p--) begin
      s[8*(3-p) +: 8] = asc(lo + r % n);
      r = r / n;
    end
    return s;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      bit nd;
      int n;
      check("cand_valid", 32'(cand_valid), 32'(m_valid));
      check("busy", 32'(busy), 32'(m_valid));
      check("done", 32'(done), 32'(m_done));
      if (m_valid) begin
        check("candidate", candidate, model_cand(m_idx, m_lo, m_hi));
        check("cand_index", 32'(cand_index), 32'(m_idx));
      end
      if (cand_valid) begin
        n_valid++;
        if (cand_index < 21'd128) seen[cand_index[6:0]] = candidate;
      end
      if (done) n_done++;
      if (cand_valid && cand_ready && !stop) n_hs++;

      nd = 1'b0;
      if (m_valid) begin
        n = m_hi - m_lo + 1;
        if (stop) m_valid = 1'b0;
        else if (cand_ready) begin
          if (m_idx == n * n * n * n - 1) begin
            m_valid = 1'b0;
            nd = 1'b1;
          end else m_idx++;
        end
      end else if (!m_done && start) begin
        m_lo = int'(from);
        m_hi = (to > 6'd35) ? 35 : int'(to);
        if (m_lo > m_hi) nd = 1'b1;
        else begin
          m_valid = 1'b1;
          m_idx = 0;
        end
      end
      m_done = nd;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    n_hs = 0;
    n_done = 0;
    n_valid = 0;
    for (int i = 0; i < 128; i++) seen[i] = '0;
  endtask

  task automatic do_start(input logic [5:0] f, input logic [5:0] t);
    from  = f;
    to    = t;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_idle(input bit random_ready, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!m_valid && !m_done) begin
        ok = 1'b1;
        break;
      end
      if (random_ready) cand_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    cand_ready = 1'b1;
    check("run_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_index(input logic [20:0] k, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (cand_valid && cand_index == k) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    check("index_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_valid", 32'(cand_valid), 32'd0);
    check("rst_cand", candidate, 32'd0);
    check("rst_index", 32'(cand_index), 32'd0);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    chk_en = 1'b1;
    cand_ready = 1'b1;

    // Binary range 0..1: 16 candidates.
    clear_stats();
    do_start(6'd0, 6'd1);
    wait_idle(1'b0, 100);
    check("t1_count", 32'(n_hs), 32'd16);
    check("t1_done", 32'(n_done), 32'd1);
    check("t1_first", seen[0], 32'h30303030);
    check("t1_idx2", seen[2], 32'h30303130);
    check("t1_last", seen[15], 32'h31313131);

    // Single-symbol range.
    clear_stats();
    do_start(6'd5, 6'd5);
    wait_idle(1'b0, 20);
    check("t2_count", 32'(n_hs), 32'd1);
    check("t2_cand", seen[0], 32'h35353535);
    check("t2_done", 32'(n_done), 32'd1);

    // Letters only, stop with a handshake at index 26.
    clear_stats();
    do_start(6'd10, 6'd35);
    wait_index(21'd26, 100);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("t3_stop_valid", 32'(cand_valid), 32'd0);
    check("t3_idx25", seen[25], 32'h6161617a);
    check("t3_idx26", seen[26], 32'h61616261);
    repeat (3) cyc();
    check("t3_no_done", 32'(n_done), 32'd0);

    // Random backpressure over 0..2.
    clear_stats();
    do_start(6'd0, 6'd2);
    wait_idle(1'b1, 1000);
    check("t4_count", 32'(n_hs), 32'd81);
    check("t4_last", seen[80], 32'h32323232);
    check("t4_done", 32'(n_done), 32'd1);

    // Empty range.
    clear_stats();
    do_start(6'd20, 6'd3);
    check("t5_done_next", 32'(done), 32'd1);
    wait_idle(1'b0, 10);
    repeat (2) cyc();
    check("t5_no_valid", 32'(n_valid), 32'd0);
    check("t5_done", 32'(n_done), 32'd1);

    // Clamp of to=63.
    clear_stats();
    do_start(6'd35, 6'd63);
    wait_idle(1'b0, 20);
    check("t5_clamp_count", 32'(n_hs), 32'd1);
    check("t5_clamp_cand", seen[0], 32'h7a7a7a7a);

    // Stop at index 7, then restart from zero.
    clear_stats();
    do_start(6'd0, 6'd1);
    wait_index(21'd7, 50);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("t6_stop_valid", 32'(cand_valid), 32'd0);
    repeat (3) cyc();
    check("t6_no_done", 32'(n_done), 32'd0);
    clear_stats();
    do_start(6'd0, 6'd1);
    check("t6_restart_idx", 32'(cand_index), 32'd0);
    check("t6_restart_cand", candidate, 32'h30303030);
    wait_idle(1'b0, 100);
    check("t6_restart_count", 32'(n_hs), 32'd16);

    // Asynchronous reset mid-run.
    do_start(6'd0, 6'd2);
    repeat (4) cyc();
    chk_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t7_valid", 32'(cand_valid), 32'd0);
    check("t7_cand", candidate, 32'd0);
    check("t7_index", 32'(cand_index), 32'd0);
    check("t7_busy_done", {30'd0, busy, done}, 32'd0);
    cyc();
    rst = 1'b0;
    m_valid = 1'b0;
    m_done  = 1'b0;
    cyc();
    chk_en = 1'b1;
    clear_stats();
    repeat (3) cyc();
    check("t7_no_done", 32'(n_done), 32'd0);
    check("t7_idle", 32'(n_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/password_candidate_gen.md
# password_candidate_gen

Upstream candidate source for `password_cracker`. It enumerates every 4-character password whose characters all lie in the charset index range [`from`, `to`] of the 36-symbol alphabet (indices 0–9 = '0'–'9', 10–35 = 'a'–'z'). It emits one ASCII candidate per accepted handshake, in odometer order with the rightmost character varying fastest. It supports backpressure, early stop on match, and a completion pulse.

## Interface

Parameters:
- `NCHARS`, 4: password length in characters.
- `CHARSET_MAX`, 35: highest legal charset index.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: begin enumeration; sampled only in IDLE.
- `from`, in, 6: lowest charset index, captured on `start`.
- `to`, in, 6: highest charset index, captured on `start`.
- `stop`, in, 1: abort enumeration (cracker found a match).
- `cand_valid`, out, 1: `candidate` is valid.
- `cand_ready`, in, 1: downstream accepts the candidate.
- `candidate`, out, 8*NCHARS: ASCII candidate; character 0 (leftmost) in [31:24].
- `cand_index`, out, 21: ordinal of the current candidate, starting at 0.
- `busy`, out, 1: high in RUN.
- `done`, out, 1: one-cycle pulse after the last candidate is accepted.

## Operation

- States: IDLE, RUN, FIN.
- **IDLE**
  - `start`=1 captures `from` and `to`.
  - If `to` > CHARSET_MAX, it is clamped to CHARSET_MAX.
  - If the captured `from` > clamped `to`: go to FIN with no candidates.
  - Otherwise: all digits ← `from`, `cand_index` ← 0, go to RUN.
- **RUN**
  - `cand_valid`=1.
  - On `cand_valid` && `cand_ready`:
    - If all digits == `to`: go to FIN.
    - Otherwise: advance the odometer and increment `cand_index`.
  - Odometer: the rightmost digit increments. A digit equal to `to` wraps to `from` and carries left.
  - While `cand_ready`=0, `candidate` and `cand_index` hold stable.
- **FIN**
  - `done`=1 for exactly one cycle, then go to IDLE.
- **`stop`**
  - `stop`=1 in RUN goes to IDLE next cycle, without a `done` pulse.
  - If `stop` and a handshake occur in the same cycle, `stop` wins and no advance is visible.
  - `stop` is ignored in IDLE and FIN.
- **`start` outside IDLE**: ignored.
- **ASCII mapping**: index i<10 → 8'h30+i; otherwise 8'h61+(i−10).
- **Range**: at most 36^4 = 1,679,616 candidates, so `cand_index` (21 bits) never overflows.

## Timing

- Reset values: `cand_valid`=0, `busy`=0, `done`=0, `candidate`=0, `cand_index`=0, state IDLE.
- Reset mid-run aborts immediately, with no `done` pulse.
- First candidate: `cand_valid` rises the cycle after `start` is sampled.
- Throughput: one candidate per cycle while `cand_ready`=1.
- Last handshake in cycle N: `done`=1 in cycle N+1, and `cand_valid`=0 from cycle N+1.
- Empty range (`from` > `to`): `done` pulses the cycle after `start`; `cand_valid` never asserts.
- `busy` equals (state == RUN).
- All outputs are registered; there is no combinational path from `cand_ready` or `stop` to any output.

## Structure

- Shared package `pc_pkg` holds:
  - `CHARSET_SIZE`=36 and `CHARSET_MAX`=35.
  - Function `idx_to_ascii(logic [5:0])`.
  - State enum for IDLE/RUN/FIN.
  - `pc_pkg` is shared with `password_cracker`, which uses the same charset.
- Sub-module `charset_digit`, instantiated NCHARS times in a carry chain:
  - Inputs: `from`, `to`, `load`, `inc`.
  - Outputs: 6-bit value and `carry_out` (`inc` && value==`to`).
- Top level: FSM, index counter, and ASCII output registers.

## Test plan

1. `from`=0, `to`=1, `cand_ready`=1: exactly 16 candidates, "0000", "0001", "0010", … "1111". `done` pulses the cycle after "1111" (index 15).
2. `from`=`to`=5: single candidate "5555" at index 0, then `done`.
3. `from`=10, `to`=35, stop after index 26: index 25 = "aaaz", index 26 = "aaba". Carry propagates correctly.
4. Backpressure: toggle `cand_ready` pseudo-randomly with `from`=0, `to`=2. All 81 candidates appear in order with no duplicates or skips. `candidate` is stable while stalled.
5. `from`=20, `to`=3: no `cand_valid`, and `done` pulses one cycle after `start`. Separately, `to`=63 clamps to 35: the last candidate with `from`=35 is "zzzz".
6. Abort cases:
   - `stop` at index 7 (together with `cand_ready`): `cand_valid`=0 next cycle, no `done`, and a new `start` restarts from index 0.
   - `rst` asserted mid-run: all outputs return to reset values asynchronously.
